// File: rtl/pcpu_memsys_if.sv
// pcpu_memsys_if: bundles the host load port, run-control pins and the CPU
// instruction/data memory ports seen by pcpu_memsys.
//   slave  : the memory system (drives ld_ready, cpu_*, busy, ld_overflow, read data)
//   master : the host/CPU side (drives load words, run/stop, addresses, stores)
interface pcpu_memsys_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_sel;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          run_req;
  logic          stop_req;
  logic          cpu_enable;
  logic          cpu_start;
  logic          busy;
  logic          ld_overflow;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_datain;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_dataout;
  logic          d_we;
  logic [DW-1:0] d_datain;

  modport slave (
    input  ld_valid, ld_sel, ld_data, ld_last, run_req, stop_req,
           i_addr, d_addr, d_dataout, d_we,
    output ld_ready, cpu_enable, cpu_start, busy, ld_overflow,
           i_datain, d_datain
  );

  modport master (
    output ld_valid, ld_sel, ld_data, ld_last, run_req, stop_req,
           i_addr, d_addr, d_dataout, d_we,
    input  ld_ready, cpu_enable, cpu_start, busy, ld_overflow,
           i_datain, d_datain
  );
endinterface

// File: rtl/pcpu_memsys.sv
// pcpu_memsys: instruction and data RAMs for the 16-bit pipeline CPU, a host
// load port (valid/ready) that fills either RAM, and the run-control FSM that
// drives the CPU enable/start pins.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-low
//   bus    - pcpu_memsys_if.slave: load port, run/stop control, CPU memory ports
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting; accepts host words or a run request
// S_LOAD  | inside a host load burst, until the word marked last
// S_START | single-cycle cpu_start pulse; load pointers are cleared
// S_RUN   | CPU executing, owns data RAM writes, until stop_req
module pcpu_memsys #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  pcpu_memsys_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_RUN} state_t;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t        state, state_next;
  logic [AW-1:0] ptr_i, ptr_d;
  logic          overflow;
  logic [DW-1:0] imem [0:(1<<AW)-1];
  logic [DW-1:0] dmem [0:(1<<AW)-1];

  logic host_window, cpu_window, accept, host_wr, cpu_wr, enter_start;

  assign host_window = (state == S_IDLE) || (state == S_LOAD);
  assign cpu_window  = (state == S_START) || (state == S_RUN);
  assign accept      = bus.ld_valid && host_window;
  // Gated by reset so a word presented during a reset edge is not written.
  assign host_wr     = accept && reset;
  assign cpu_wr      = bus.d_we && cpu_window && reset;
  assign enter_start = (state == S_IDLE) && (state_next == S_START);

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        // A host word takes priority over run_req in the same cycle.
        if (accept)           state_next = bus.ld_last ? S_IDLE : S_LOAD;
        else if (bus.run_req) state_next = S_START;
      end
      S_LOAD: begin
        if (accept && bus.ld_last) state_next = S_IDLE;
      end
      S_START: state_next = bus.stop_req ? S_IDLE : S_RUN;
      S_RUN: begin
        if (bus.stop_req) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_i    <= '0;
      ptr_d    <= '0;
      overflow <= 1'b0;
    end else if (enter_start) begin
      ptr_i    <= '0;
      ptr_d    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      if (bus.ld_sel) begin
        ptr_d <= ptr_d + PTR_ONE;
        if (ptr_d == '1) overflow <= 1'b1;
      end else begin
        ptr_i <= ptr_i + PTR_ONE;
        if (ptr_i == '1) overflow <= 1'b1;
      end
    end
  end

  // RAM contents are deliberately not reset. Host and CPU writes are
  // exclusive by state, so the data RAM needs no arbitration.
  always_ff @(posedge clock) begin
    if (host_wr && !bus.ld_sel) imem[ptr_i] <= bus.ld_data;
    if (host_wr && bus.ld_sel)  dmem[ptr_d] <= bus.ld_data;
    else if (cpu_wr)            dmem[bus.d_addr] <= bus.d_dataout;
  end

  assign bus.i_datain    = imem[bus.i_addr];
  assign bus.d_datain    = dmem[bus.d_addr];
  assign bus.ld_ready    = host_window;
  assign bus.cpu_enable  = cpu_window;
  assign bus.cpu_start   = (state == S_START);
  assign bus.busy        = (state != S_IDLE);
  assign bus.ld_overflow = overflow;
endmodule

// File: tb/tb_pcpu_memsys.sv
// tb_pcpu_memsys: directed vector table for load/run/stop/store behaviour,
// plus hand-written sequences for pointer wrap and reset in LOAD/RUN.
module tb_pcpu_memsys;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  pcpu_memsys_if #(.AW(8), .DW(16)) bus ();

  pcpu_memsys #(.AW(8), .DW(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        v, sel;
    logic [15:0] data;
    logic        last, run, stop, we;
    logic [7:0]  daddr;
    logic [15:0] dout;
    logic [7:0]  iaddr;
    logic        rdy, bsy, en, st, ovf, ci;
    logic [15:0] ei;
    logic        cd;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic rdy, input logic bsy,
                         input logic en, input logic st, input logic ovf);
    chk({tag, ".ld_ready"},    16'(bus.ld_ready),    16'(rdy));
    chk({tag, ".busy"},        16'(bus.busy),        16'(bsy));
    chk({tag, ".cpu_enable"},  16'(bus.cpu_enable),  16'(en));
    chk({tag, ".cpu_start"},   16'(bus.cpu_start),   16'(st));
    chk({tag, ".ld_overflow"}, 16'(bus.ld_overflow), 16'(ovf));
  endtask

  task automatic idle_inputs();
    bus.ld_valid = 0; bus.ld_sel = 0; bus.ld_data = '0; bus.ld_last = 0;
    bus.run_req = 0;  bus.stop_req = 0; bus.d_we = 0;
    bus.d_addr = '0;  bus.d_dataout = '0; bus.i_addr = '0;
  endtask

  task automatic load_word(input logic sel, input logic [15:0] data, input logic last);
    bus.ld_valid = 1; bus.ld_sel = sel; bus.ld_data = data; bus.ld_last = last;
    tick();
    bus.ld_valid = 0; bus.ld_last = 0;
  endtask

  initial begin
    //            v sel data     last run stop we daddr  dout      iaddr | rdy bsy en st ovf ci ei        cd ed
    vecs[0]  = '{1,0,16'h8101,0,0,0,0,8'h00,16'h0000,8'h00, 1,1,0,0,0, 1,16'h8101, 0,16'h0000};
    vecs[1]  = '{1,0,16'h8202,0,0,0,0,8'h00,16'h0000,8'h01, 1,1,0,0,0, 1,16'h8202, 0,16'h0000};
    vecs[2]  = '{1,0,16'h0800,1,0,0,0,8'h00,16'h0000,8'h02, 1,0,0,0,0, 1,16'h0800, 0,16'h0000};
    vecs[3]  = '{1,1,16'h1234,1,0,0,0,8'h00,16'h0000,8'h00, 1,0,0,0,0, 1,16'h8101, 1,16'h1234};
    vecs[4]  = '{1,0,16'h5555,1,0,0,0,8'h00,16'h0000,8'h03, 1,0,0,0,0, 1,16'h5555, 1,16'h1234};
    vecs[5]  = '{0,0,16'h0000,0,1,0,0,8'h00,16'h0000,8'h00, 0,1,1,1,0, 1,16'h8101, 0,16'h0000};
    vecs[6]  = '{0,0,16'h0000,0,0,0,0,8'h00,16'h0000,8'h00, 0,1,1,0,0, 0,16'h0000, 0,16'h0000};
    vecs[7]  = '{0,0,16'h0000,0,0,0,1,8'h10,16'hBEEF,8'h00, 0,1,1,0,0, 0,16'h0000, 1,16'hBEEF};
    vecs[8]  = '{1,0,16'hDEAD,1,0,0,0,8'h00,16'h0000,8'h00, 0,1,1,0,0, 1,16'h8101, 0,16'h0000};
    vecs[9]  = '{0,0,16'h0000,0,0,1,0,8'h00,16'h0000,8'h00, 1,0,0,0,0, 0,16'h0000, 0,16'h0000};
    vecs[10] = '{0,0,16'h0000,0,0,0,1,8'h10,16'h1111,8'h00, 1,0,0,0,0, 0,16'h0000, 1,16'hBEEF};
    vecs[11] = '{1,1,16'h7777,0,1,0,0,8'h00,16'h0000,8'h00, 1,1,0,0,0, 0,16'h0000, 1,16'h7777};
    vecs[12] = '{1,1,16'h8888,1,1,1,0,8'h01,16'h0000,8'h00, 1,0,0,0,0, 0,16'h0000, 1,16'h8888};
    vecs[13] = '{0,0,16'h0000,0,1,0,0,8'h00,16'h0000,8'h00, 0,1,1,1,0, 0,16'h0000, 0,16'h0000};
    vecs[14] = '{0,0,16'h0000,0,0,1,0,8'h00,16'h0000,8'h00, 1,0,0,0,0, 0,16'h0000, 0,16'h0000};
    vecs[15] = '{0,0,16'h0000,0,0,1,0,8'h00,16'h0000,8'h00, 1,0,0,0,0, 0,16'h0000, 0,16'h0000};

    idle_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
    chk_ctl("reset", 1, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = vecs[i].v;    bus.ld_sel = vecs[i].sel;  bus.ld_data = vecs[i].data;
      bus.ld_last = vecs[i].last;  bus.run_req = vecs[i].run; bus.stop_req = vecs[i].stop;
      bus.d_we = vecs[i].we;       bus.d_addr = vecs[i].daddr;
      bus.d_dataout = vecs[i].dout; bus.i_addr = vecs[i].iaddr;
      tick();
      chk_ctl($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].bsy, vecs[i].en, vecs[i].st, vecs[i].ovf);
      if (vecs[i].ci) chk($sformatf("vec%0d.i_datain", i), bus.i_datain, vecs[i].ei);
      if (vecs[i].cd) chk($sformatf("vec%0d.d_datain", i), bus.d_datain, vecs[i].ed);
    end
    idle_inputs();

    // Pointer wrap: 257 imem words; word k lands at (k-1) mod 256.
    for (int k = 1; k <= 257; k++) begin
      load_word(0, 16'hA000 + 16'(k), (k == 257));
      if (k == 255) chk("wrap.ovf_before", 16'(bus.ld_overflow), 16'h0000);
      if (k == 256) chk("wrap.ovf_set", 16'(bus.ld_overflow), 16'h0001);
    end
    chk_ctl("wrap.end", 1, 0, 0, 0, 1);
    bus.i_addr = 8'h00; #1 chk("wrap.imem0", bus.i_datain, 16'hA101);
    bus.i_addr = 8'h01; #1 chk("wrap.imem1", bus.i_datain, 16'hA002);
    bus.i_addr = 8'hFF; #1 chk("wrap.imem255", bus.i_datain, 16'hA100);
    bus.run_req = 1;
    tick();
    bus.run_req = 0;
    chk_ctl("wrap.start", 0, 1, 1, 1, 0);
    bus.stop_req = 1;
    tick();
    bus.stop_req = 0;
    chk_ctl("wrap.stop", 1, 0, 0, 0, 0);

    // Reset in the middle of a dmem load burst.
    load_word(1, 16'h4001, 0);
    load_word(1, 16'h4002, 0);
    chk_ctl("rstld.pre", 1, 1, 0, 0, 0);
    reset = 0;
    tick();
    reset = 1;
    chk_ctl("rstld.post", 1, 0, 0, 0, 0);
    load_word(1, 16'h4444, 1);
    bus.d_addr = 8'h00; #1 chk("rstld.dmem0", bus.d_datain, 16'h4444);
    bus.d_addr = 8'h01; #1 chk("rstld.dmem1_kept", bus.d_datain, 16'h4002);

    // Reset while running.
    bus.run_req = 1;
    tick();
    bus.run_req = 0;
    tick();
    chk_ctl("rstrun.pre", 0, 1, 1, 0, 0);
    reset = 0;
    tick();
    reset = 1;
    chk_ctl("rstrun.post", 1, 0, 0, 0, 0);
    load_word(0, 16'h6060, 1);
    bus.i_addr = 8'h00; #1 chk("rstrun.imem0", bus.i_datain, 16'h6060);

    // stop_req in RUN drops cpu_enable the following cycle.
    bus.run_req = 1;
    tick();
    bus.run_req = 0;
    tick();
    chk_ctl("stop.run", 0, 1, 1, 0, 0);
    bus.stop_req = 1;
    tick();
    bus.stop_req = 0;
    chk_ctl("stop.idle", 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
